// File: rtl/vedic_pkg.sv
// vedic_pkg: shared constants, stage-valid type and width check for the Vedic multipliers
package vedic_pkg;
    localparam int LEAF_WIDTH = 8;
    localparam int MUL_LATENCY = 3;
    typedef logic [MUL_LATENCY-1:0] stage_vld_t;
    function automatic bit is_valid_width(input int w);
        return w >= 8 && w <= 64 && (w & (w - 1)) == 0;
    endfunction
endpackage

// File: rtl/vedic_mul_core.sv
// vedic_mul_core: combinational unsigned WxW Urdhva-Tiryagbhyam multiplier, recursive down to an 8x8 leaf
module vedic_mul_core
    import vedic_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p
);
    if (W < LEAF_WIDTH) begin : g_direct
        assign p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    end else if (W == LEAF_WIDTH) begin : g_leaf
        logic [$clog2(LEAF_WIDTH):0] col;
        // vertical-crosswise: sum each anti-diagonal column, then weight it by its position
        always_comb begin
            p = '0;
            col = '0;
            for (int k = 0; k < 2*W-1; k++) begin
                col = '0;
                for (int i = 0; i < W; i++)
                    for (int j = 0; j < W; j++)
                        if (i + j == k) col = col + ($clog2(LEAF_WIDTH)+1)'(a[i] & b[j]);
                p = p + ((2*W)'(col) << k);
            end
        end
    end else begin : g_rec
        localparam int H = W / 2;
        logic [W-1:0] ll, lh, hl, hh;
        vedic_mul_core #(.W(H)) u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(ll));
        vedic_mul_core #(.W(H)) u_lh (.a(a[H-1:0]), .b(b[W-1:H]), .p(lh));
        vedic_mul_core #(.W(H)) u_hl (.a(a[W-1:H]), .b(b[H-1:0]), .p(hl));
        vedic_mul_core #(.W(H)) u_hh (.a(a[W-1:H]), .b(b[W-1:H]), .p(hh));
        assign p = {hh, ll} + (((2*W)'(lh) + (2*W)'(hl)) << H);
    end
endmodule

// File: rtl/vedic_mul_pipe.sv
// vedic_mul_pipe: 3-stage streaming Vedic multiplier with signed/unsigned mode, tag and valid/ready
module vedic_mul_pipe
    import vedic_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_signed,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_y,
    output logic [TAG_WIDTH-1:0] out_tag
);
    localparam int H = WIDTH / 2;

    if (!is_valid_width(WIDTH) || TAG_WIDTH < 1) begin : g_bad_param
        $error("vedic_mul_pipe: WIDTH must be a power of two in 8..64 and TAG_WIDTH >= 1");
    end

    stage_vld_t vld;
    logic en;
    logic [WIDTH-1:0] a_mag, b_mag, s1_a, s1_b;
    logic [WIDTH-1:0] ll, lh, hl, hh, s2_ll, s2_lh, s2_hl, s2_hh;
    logic [2*WIDTH-1:0] sum, y;
    logic [TAG_WIDTH-1:0] s1_tag, s2_tag;
    logic s1_neg, s2_neg;

    // the whole pipe freezes as one while the output beat is blocked
    assign en = out_ready | ~out_valid;
    assign in_ready = en;
    assign out_valid = vld[MUL_LATENCY-1];

    assign a_mag = (in_signed & in_a[WIDTH-1]) ? -in_a : in_a;
    assign b_mag = (in_signed & in_b[WIDTH-1]) ? -in_b : in_b;

    vedic_mul_core #(.W(H)) u_ll (.a(s1_a[H-1:0]),     .b(s1_b[H-1:0]),     .p(ll));
    vedic_mul_core #(.W(H)) u_lh (.a(s1_a[H-1:0]),     .b(s1_b[WIDTH-1:H]), .p(lh));
    vedic_mul_core #(.W(H)) u_hl (.a(s1_a[WIDTH-1:H]), .b(s1_b[H-1:0]),     .p(hl));
    vedic_mul_core #(.W(H)) u_hh (.a(s1_a[WIDTH-1:H]), .b(s1_b[WIDTH-1:H]), .p(hh));

    // magnitude product always fits 2*WIDTH bits, so no carry out is kept
    assign sum = {s2_hh, s2_ll} + (((2*WIDTH)'(s2_lh) + (2*WIDTH)'(s2_hl)) << H);
    assign y = s2_neg ? -sum : sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            s1_a <= '0;
            s1_b <= '0;
            s1_neg <= 1'b0;
            s1_tag <= '0;
            s2_ll <= '0;
            s2_lh <= '0;
            s2_hl <= '0;
            s2_hh <= '0;
            s2_neg <= 1'b0;
            s2_tag <= '0;
            out_y <= '0;
            out_tag <= '0;
        end else if (en) begin
            vld <= {vld[MUL_LATENCY-2:0], in_valid};
            s1_a <= a_mag;
            s1_b <= b_mag;
            s1_neg <= in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
            s1_tag <= in_tag;
            s2_ll <= ll;
            s2_lh <= lh;
            s2_hl <= hl;
            s2_hh <= hh;
            s2_neg <= s1_neg;
            s2_tag <= s1_tag;
            out_y <= y;
            out_tag <= s2_tag;
        end
    end
endmodule

// File: tb/tb_vedic_mul_pipe.sv
// tb_vedic_mul_pipe: directed vectors plus a short random stream checked through an expected-result queue
module tb_vedic_mul_pipe;
    localparam int W = 16;
    localparam int TW = 4;

    logic clk = 1'b0;
    logic rst, in_valid, in_ready, in_signed, out_valid, out_ready;
    logic [W-1:0] in_a, in_b;
    logic [TW-1:0] in_tag, out_tag;
    logic [2*W-1:0] out_y;

    typedef struct packed {
        logic [2*W-1:0] y;
        logic [TW-1:0]  tag;
    } beat_t;
    beat_t exp_q[$];

    int n_tests = 0, n_fail = 0, run = 0, max_run = 0, last_wait = 0;
    bit rnd;

    always #5 clk = ~clk;

    vedic_mul_pipe #(.WIDTH(W), .TAG_WIDTH(TW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_tag(out_tag)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
        logic signed [31:0] sa, sb;
        sa = s ? {{16{a[15]}}, a} : {16'b0, a};
        sb = s ? {{16{b[15]}}, b} : {16'b0, b};
        return 32'(sa * sb);
    endfunction

    // results are consumed at the next rising edge when valid and ready are seen here
    always @(negedge clk) begin
        run = out_valid ? run + 1 : 0;
        if (run > max_run) max_run = run;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("spurious", 64'(exp_q.size()), 64'd1);
            else begin
                beat_t e;
                e = exp_q.pop_front();
                check("out_y", 64'(out_y), 64'(e.y));
                check("out_tag", 64'(out_tag), 64'(e.tag));
            end
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input logic [3:0] t, input logic [31:0] y);
        int w = 0;
        in_valid = 1'b1; in_a = a; in_b = b; in_signed = s; in_tag = t;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            w++;
            @(negedge clk);
        end
        last_wait = w;
        check("accept", 64'(in_ready), 64'd1);
        if (in_ready) exp_q.push_back({y, t});
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int w = 0;
        while (exp_q.size() != 0 && w < 500) begin
            @(posedge clk);
            w++;
        end
        #1;
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; in_tag = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_y", 64'(out_y), 64'd0);
        check("rst_tag", 64'(out_tag), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);

        send(16'hFFFF, 16'hFFFF, 1'b0, 4'd3, 32'hFFFE0001);
        check("lat_n0", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check("lat_n1", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check("lat_n2_valid", 64'(out_valid), 64'd1);
        check("lat_n2_y", 64'(out_y), 64'hFFFE0001);
        check("lat_n2_tag", 64'(out_tag), 64'd3);

        send(16'h8000, 16'h8000, 1'b1, 4'd1, 32'h40000000);
        send(16'hFFFF, 16'h0003, 1'b1, 4'd2, 32'hFFFFFFFD);
        send(16'hFFFF, 16'h0003, 1'b0, 4'd4, 32'h0002FFFD);
        send(16'h0000, 16'h8000, 1'b1, 4'd5, 32'h00000000);
        send(16'h7FFF, 16'h8000, 1'b1, 4'd6, 32'hC0008000);
        send(16'h8000, 16'h0001, 1'b1, 4'd7, 32'hFFFF8000);
        send(16'hFFFF, 16'hFFFF, 1'b1, 4'd8, 32'h00000001);
        wait_empty();

        repeat (3) begin @(posedge clk); #1; end
        max_run = 0;
        for (int i = 0; i < 8; i++) begin
            send(16'(i + 1), 16'(i + 3), 1'b0, 4'(i), 32'((i + 1) * (i + 3)));
            check("b2b_ready", 64'(last_wait), 64'd0);
        end
        wait_empty();
        check("b2b_run", 64'(max_run), 64'd8);

        out_ready = 1'b0;
        send(16'h1234, 16'h0010, 1'b0, 4'd9, 32'h00012340);
        send(16'h0100, 16'h0100, 1'b0, 4'd10, 32'h00010000);
        send(16'hFFFE, 16'h0002, 1'b1, 4'd11, 32'hFFFFFFFC);
        fork
            send(16'h0003, 16'h0005, 1'b0, 4'd12, 32'h0000000F);
            begin
                repeat (5) begin
                    @(negedge clk);
                    check("stall_ready", 64'(in_ready), 64'd0);
                    check("stall_valid", 64'(out_valid), 64'd1);
                    check("stall_y", 64'(out_y), 64'h00012340);
                    check("stall_tag", 64'(out_tag), 64'd9);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_empty();

        send(16'd2, 16'd3, 1'b0, 4'd13, 32'd6);
        send(16'd4, 16'd5, 1'b0, 4'd14, 32'd20);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_y", 64'(out_y), 64'd0);
        check("mid_rst_tag", 64'(out_tag), 64'd0);
        repeat (10) begin @(posedge clk); #1; end

        rnd = 1'b1;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    logic [15:0] a, b;
                    logic s;
                    a = 16'($urandom);
                    b = 16'($urandom);
                    s = 1'($urandom_range(0, 1));
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    send(a, b, s, 4'(i), model(a, b, s));
                end
                rnd = 1'b0;
            end
            begin
                while (rnd) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        wait_empty();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
